chip8_timers: RTL and testbench

CHIP-8 delay timer (DT) and sound timer (ST) register file with an audio tone generator. It sits directly downstream of `timer`, consuming its `timer_60hz_tick` strobe, and upstream of the CPU datapath (FX07/FX15/FX18) and the buzzer pin. Each 60 Hz tick decrements both timers toward zero. While ST is nonzero, the block drives a square-wave tone.

---
 rtl/chip8_timers.sv | 88 ++++++++
 tb/tb_chip8_timers.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_timers.sv
// CHIP-8 delay and sound timers with a square-wave tone generator.
// Both timers count down on the 60 Hz strobe; the tone runs while ST is nonzero.
module chip8_timers #(
    parameter int unsigned TONE_HALF_PERIOD = 114
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_60hz,
    input  logic       freeze,
    input  logic       dt_we,
    input  logic       st_we,
    input  logic [7:0] wdata,
    output logic [7:0] dt_value,
    output logic [7:0] st_value,
    output logic       sound_active,
    output logic       tone,
    output logic       dt_expired
);

    localparam logic [15:0] TONE_LAST = 16'(TONE_HALF_PERIOD - 1);

    logic [7:0]  dt_q, dt_d;
    logic [7:0]  st_q, st_d;
    logic        exp_q, exp_d;
    logic        tone_q, tone_d;
    logic [15:0] cnt_q, cnt_d;
    logic        dec_en;

    assign dec_en = tick_60hz && !freeze;

    always_comb begin
        dt_d  = dt_q;
        exp_d = 1'b0;
        if (dt_we) begin
            dt_d = wdata;
        end else if (dec_en && dt_q != 8'd0) begin
            dt_d  = dt_q - 8'd1;
            exp_d = (dt_q == 8'd1);
        end
    end

    always_comb begin
        st_d = st_q;
        if (st_we) begin
            st_d = wdata;
        end else if (dec_en && st_q != 8'd0) begin
            st_d = st_q - 8'd1;
        end
    end

    // Phase is kept across ST reloads; only silence resets the waveform.
    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (st_q == 8'd0) begin
            cnt_d  = 16'd0;
            tone_d = 1'b0;
        end else if (cnt_q == TONE_LAST) begin
            cnt_d  = 16'd0;
            tone_d = ~tone_q;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dt_q   <= 8'd0;
            st_q   <= 8'd0;
            exp_q  <= 1'b0;
            tone_q <= 1'b0;
            cnt_q  <= 16'd0;
        end else begin
            dt_q   <= dt_d;
            st_q   <= st_d;
            exp_q  <= exp_d;
            tone_q <= tone_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dt_value     = dt_q;
    assign st_value     = st_q;
    assign sound_active = (st_q != 8'd0);
    assign tone         = tone_q;
    assign dt_expired   = exp_q;

endmodule

// File: tb/tb_chip8_timers.sv
// Directed bench for chip8_timers: per-cycle vector table plus
// multi-cycle sequences for countdown, tone, freeze and a long run.
module tb_chip8_timers;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_60hz = 1'b0;
    logic       freeze = 1'b0;
    logic       dt_we = 1'b0;
    logic       st_we = 1'b0;
    logic [7:0] wdata = 8'd0;
    logic [7:0] dt_value, st_value;
    logic       sound_active, tone, dt_expired;

    int checks = 0;
    int errors = 0;

    chip8_timers #(.TONE_HALF_PERIOD(4)) dut (
        .clk(clk),
        .reset(reset),
        .tick_60hz(tick_60hz),
        .freeze(freeze),
        .dt_we(dt_we),
        .st_we(st_we),
        .wdata(wdata),
        .dt_value(dt_value),
        .st_value(st_value),
        .sound_active(sound_active),
        .tone(tone),
        .dt_expired(dt_expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       tk;
        logic       frz;
        logic       dwe;
        logic       swe;
        logic [7:0] wd;
        logic [7:0] edt;
        logic [7:0] est;
        logic       eexp;
        logic       esnd;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0;
        tick_60hz = 1'b0;
        freeze = 1'b0;
        dt_we = 1'b0;
        st_we = 1'b0;
        wdata = 8'd0;
    endtask

    initial begin
        int  pulses;
        int  pulse_tick;
        int  ticks;
        int  toggles;
        logic tone_prev;
        logic tone_seen;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  8'd0,   1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3,   8'd3,  8'd0,   1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd3,  8'd0,   1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd2,  8'd0,   1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd1,  8'd0,   1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  8'd0,   1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  8'd0,   1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  8'd0,   1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd10,  8'd10, 8'd0,   1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd7,   8'd7,  8'd0,   1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd6,  8'd0,   1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1,   8'd1,  8'd0,   1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   8'd0,  8'd0,   1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd5,   8'd5,  8'd5,   1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0,   8'd5,  8'd0,   1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   8'd5,  8'd0,   1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd4,  8'd0,   1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1,   8'd4,  8'd1,   1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd3,  8'd0,   1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd9,   8'd0,  8'd0,   1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  8'd0,   1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd255, 8'd0,  8'd255, 1'b0, 1'b1};
        vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  8'd254, 1'b0, 1'b1};
        vecs[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  8'd0,   1'b0, 1'b0};

        // Reset with both timers loaded, held for two cycles.
        cyc();
        idle();
        dt_we = 1'b1;
        st_we = 1'b1;
        wdata = 8'd5;
        cyc();
        idle();
        chk("load_dt5", int'(dt_value), 5);
        chk("load_st5", int'(st_value), 5);
        repeat (6) cyc();
        reset = 1'b1;
        cyc();
        chk("rst_dt", int'(dt_value), 0);
        chk("rst_st", int'(st_value), 0);
        chk("rst_snd", int'(sound_active), 0);
        chk("rst_tone", int'(tone), 0);
        chk("rst_exp", int'(dt_expired), 0);
        cyc();
        idle();
        tick_60hz = 1'b1;
        cyc();
        idle();
        chk("tick_after_rst_dt", int'(dt_value), 0);
        chk("tick_after_rst_st", int'(st_value), 0);
        tone_seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            cyc();
            if (tone) tone_seen = 1'b1;
        end
        chk("tone_quiet_500", int'(tone_seen), 0);

        // Per-cycle vector table.
        for (int i = 0; i < 24; i++) begin
            reset     = vecs[i].rst;
            tick_60hz = vecs[i].tk;
            freeze    = vecs[i].frz;
            dt_we     = vecs[i].dwe;
            st_we     = vecs[i].swe;
            wdata     = vecs[i].wd;
            cyc();
            chk($sformatf("vec%0d_dt", i), int'(dt_value), int'(vecs[i].edt));
            chk($sformatf("vec%0d_st", i), int'(st_value), int'(vecs[i].est));
            chk($sformatf("vec%0d_exp", i), int'(dt_expired), int'(vecs[i].eexp));
            chk($sformatf("vec%0d_snd", i), int'(sound_active), int'(vecs[i].esnd));
        end
        idle();
        cyc();

        // DT countdown with ticks 10 cycles apart.
        dt_we = 1'b1;
        wdata = 8'd3;
        cyc();
        idle();
        pulses = 0;
        for (int t = 1; t <= 4; t++) begin
            repeat (9) begin
                cyc();
                if (dt_expired) pulses++;
            end
            tick_60hz = 1'b1;
            cyc();
            tick_60hz = 1'b0;
            chk($sformatf("cd_tick%0d_dt", t), int'(dt_value), (t >= 3) ? 0 : 3 - t);
            chk($sformatf("cd_tick%0d_exp", t), int'(dt_expired), (t == 3) ? 1 : 0);
        end
        cyc();
        if (dt_expired) pulses++;
        chk("cd_stray_pulses", pulses, 0);

        // Tone: ST=2 written at step 0, ticks at steps 13 and 23.
        dt_we = 1'b0;
        st_we = 1'b1;
        wdata = 8'd2;
        cyc();
        idle();
        chk("tone_snd_start", int'(sound_active), 1);
        chk("tone_start_low", int'(tone), 0);
        for (int k = 1; k <= 40; k++) begin
            tick_60hz = (k == 13 || k == 23);
            cyc();
            tick_60hz = 1'b0;
            chk($sformatf("tone_k%0d", k), int'(tone), (k <= 23) ? (k / 4) % 2 : 0);
            chk($sformatf("snd_k%0d", k), int'(sound_active), (k < 23) ? 1 : 0);
        end

        // Freeze suppresses decrements but not the tone.
        dt_we = 1'b1;
        st_we = 1'b1;
        wdata = 8'd4;
        cyc();
        idle();
        freeze = 1'b1;
        toggles = 0;
        tone_prev = tone;
        for (int t = 0; t < 5; t++) begin
            tick_60hz = 1'b1;
            cyc();
            tick_60hz = 1'b0;
            if (tone != tone_prev) toggles++;
            tone_prev = tone;
            repeat (2) begin
                cyc();
                if (tone != tone_prev) toggles++;
                tone_prev = tone;
            end
        end
        chk("frz_dt", int'(dt_value), 4);
        chk("frz_st", int'(st_value), 4);
        chk("frz_tone_runs", int'(toggles >= 3), 1);
        freeze = 1'b0;
        tick_60hz = 1'b1;
        cyc();
        idle();
        chk("unfrz_dt", int'(dt_value), 3);
        chk("unfrz_st", int'(st_value), 3);

        // Long run: periodic strobe every 20 cycles, DT=60.
        dt_we = 1'b1;
        st_we = 1'b1;
        wdata = 8'd60;
        cyc();
        idle();
        pulses = 0;
        pulse_tick = -1;
        ticks = 0;
        for (int c = 0; c < 62 * 20; c++) begin
            tick_60hz = (c % 20 == 19);
            cyc();
            if (tick_60hz) ticks++;
            tick_60hz = 1'b0;
            if (dt_expired) begin
                pulses++;
                pulse_tick = ticks;
            end
        end
        chk("long_dt", int'(dt_value), 0);
        chk("long_st", int'(st_value), 0);
        chk("long_pulses", pulses, 1);
        chk("long_pulse_tick", pulse_tick, 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
